instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage that drives the IF/ID pipeline register. It owns the program counter and issues word reads to instruction memory over a req/ready handshake. It presents each fetched instruction with its PC+4 to IF/ID and honours the same `freeze` stall and branch redirect that control IF/ID. It inserts NOP bubbles (all-zero instruction, PC 0) whenever no valid instruction is available.

## Interface
- `WORD_LEN`, 32: data and address width, from the shared defines.
- `RESET_PC`, 0: first fetch address after reset.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `freeze`  in  1: IF/ID is stalled this cycle, so the current output is not consumed.
- `branch_taken`  in  1: single-cycle redirect pulse; the current output is wrong-path.
- `branch_target`  in  WORD_LEN: redirect address; bits [1:0] are forced to 0.
- `mem_req`  out  1: read request, held until accepted.
- `mem_addr`  out  WORD_LEN: word-aligned read address.
- `mem_ready`  in  1: read complete; `mem_rdata` is valid this cycle.
- `mem_rdata`  in  WORD_LEN: instruction word.
- `PC`  out  WORD_LEN: address of the presented instruction + 4; feeds IF/ID `PCIn`.
- `instruction`  out  WORD_LEN: presented instruction; 0 (NOP) when `valid`=0.
- `valid`  out  1: output slot holds a real fetched instruction.

## Operation
- State machine states:
  - IDLE: one cycle after reset release.
  - REQ: request outstanding.
  - HOLD: data parked in the skid buffer, no request outstanding.
  - DISCARD: wrong-path request outstanding.
- IDLE → REQ: `mem_req`<=1 and `mem_addr`<=`RESET_PC`.
- REQ, `mem_ready`=1, no redirect, and the output slot is free (`freeze`=0 or `valid`=0):
  - Output <= {`mem_rdata`, `mem_addr`+4, valid=1}.
  - Issue the next request to `mem_addr`+4 in the same edge; stay in REQ.
- REQ, `mem_ready`=1, `freeze`=1 and `valid`=1:
  - Park the word and its address in the skid buffer, deassert `mem_req`, go to HOLD.
- HOLD, `freeze`=0: output <= skid contents, request skid address+4, go to REQ.
- Output slot consumed (`freeze`=0) with nothing new to load: output <= bubble {0, 0, valid=0}.
- `branch_taken`=1 takes precedence over `freeze` and `mem_ready`:
  - Output <= bubble regardless of `freeze`, and the skid buffer is cleared.
  - If no request is outstanding, or `mem_ready`=1 in the same cycle: drop any returned data, request the target, go to REQ.
  - If a request is outstanding without `mem_ready`: latch the target, go to DISCARD.
- DISCARD:
  - On `mem_ready`: drop the data, request the latched target, go to REQ.
  - A further `branch_taken` overwrites the latched target (latest wins).
- Address arithmetic: +4, modulo 2^WORD_LEN, so 0xFFFF_FFFC wraps to 0x0000_0000.

## Timing
- All outputs are registered.
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `PC`=0, `instruction`=0, `valid`=0, state=IDLE, skid empty.
- Async assertion mid-transaction abandons the outstanding request; memory must tolerate a dropped request.
- `mem_req` and `mem_addr` are stable from assertion until the cycle `mem_ready`=1.
- Zero-wait memory (`mem_ready` high in the first request cycle) gives back-to-back issue: one instruction per cycle, the first `valid` output 2 cycles after reset release.
- Fetch-to-output latency: the output updates at the edge where `mem_ready` is sampled.
- Redirect: the first target request is on `mem_addr` the cycle after `branch_taken` when idle or completing. Otherwise it follows the cycle after the outstanding `mem_ready`.
- No instruction is ever duplicated or lost across `freeze`.

## Structure
- The shared defines file holds `WORD_LEN`, the NOP value (0) and the state encodings IDLE/REQ/HOLD/DISCARD.
- One sub-module, `fetch_skid_buf`: a one-entry {instruction, address} buffer with load/clear/full signals.
- The PC/address adder and FSM stay in `instr_fetch_unit`.

## Test plan
- Reset release, zero-wait memory returning addr>>2 as data → `mem_addr` 0,4,8…; outputs (PC,instr) = (4,0),(8,1),(12,2), `valid`=1 every cycle.
- `mem_ready` delayed 3 cycles → `mem_addr` held for 3 cycles, bubbles output meanwhile, then one valid instruction.
- `freeze` held 4 cycles with a fetch completing inside it → skid captures, `mem_req`=0 in HOLD, outputs frozen; after release the sequence resumes with no gap or duplicate.
- `branch_taken` with target 0x100 while a read is outstanding → returned word dropped, next `mem_addr`=0x100, output bubble, then PC=0x104.
- `branch_taken` and `freeze` together while HOLD holds data → skid cleared, output bubble, request 0x100 next cycle.
- `RESET_PC`=0xFFFFFFFC → second request address 0x0; `rst` low mid-wait → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: word width, NOP value, FSM encoding, output slot type.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

  localparam int WORD_LEN = 32;

  localparam logic [WORD_LEN-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // one cycle after reset release
    ST_REQ     = 2'd1,  // request outstanding
    ST_HOLD    = 2'd2,  // word parked in skid buffer, no request outstanding
    ST_DISCARD = 2'd3   // wrong-path request outstanding
  } fetch_state_t;

  // Contents of the IF/ID-facing output slot.
  typedef struct packed {
    logic [WORD_LEN-1:0] instr;
    logic [WORD_LEN-1:0] pc;
    logic                vld;
  } fetch_out_t;

  localparam fetch_out_t BUBBLE = '{instr: NOP_INSTR, pc: '0, vld: 1'b0};

  function automatic logic [WORD_LEN-1:0] word_align(input logic [WORD_LEN-1:0] a);
    return {a[WORD_LEN-1:2], 2'b00};
  endfunction

  // Wraps modulo 2^WORD_LEN.
  function automatic logic [WORD_LEN-1:0] next_word(input logic [WORD_LEN-1:0] a);
    return a + WORD_LEN'(4);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: req/ready handshake with address and returned word.
// Latency: request completes in the cycle ready is high (any number of wait cycles).
// Backpressure: req and addr are held stable by the master until ready is seen.
// Ports: mem_req/mem_addr (master -> memory), mem_ready/mem_rdata (memory -> master).
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic                mem_req;
  logic [WORD_LEN-1:0] mem_addr;
  logic                mem_ready;
  logic [WORD_LEN-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit_skid_buf.sv
// One-entry {instruction, address} skid buffer for a word returned while IF/ID is frozen.
// Latency: loaded contents visible the cycle after load; clear wins over load.
// Backpressure: none internally; the owner loads only when empty and drains on unfreeze.
// Ports: clk/rst, load/clear controls, instr_in/addr_in data, full/instr/addr state.
module fetch_skid_buf
  import instr_fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                clear,
  input  logic [WORD_LEN-1:0] instr_in,
  input  logic [WORD_LEN-1:0] addr_in,
  output logic                full,
  output logic [WORD_LEN-1:0] instr,
  output logic [WORD_LEN-1:0] addr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full  <= 1'b0;
      instr <= NOP_INSTR;
      addr  <= '0;
    end else if (clear) begin
      full  <= 1'b0;
      instr <= NOP_INSTR;
      addr  <= '0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= instr_in;
      addr  <= addr_in;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, presents {instr, PC+4, valid} to IF/ID.
// Latency: output updates on the edge mem_ready is sampled; zero-wait memory gives 1 instr/cycle.
// Backpressure: freeze holds the output slot; a word arriving under freeze is parked in a skid.
// Ports: clk, rst (async active-low), freeze, branch_taken/branch_target, mem (master),
//        PC/instruction/valid (registered output slot).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_target,
  instr_fetch_unit_if.master  mem,
  output logic [WORD_LEN-1:0] PC,
  output logic [WORD_LEN-1:0] instruction,
  output logic                valid
);

  localparam logic [WORD_LEN-1:0] RESET_ADDR = {RESET_PC[WORD_LEN-1:2], 2'b00};

  fetch_state_t        state, state_nxt;
  logic                req_q, req_nxt;
  logic [WORD_LEN-1:0] addr_q, addr_nxt;
  logic [WORD_LEN-1:0] target_q, target_nxt;
  fetch_out_t          out_q, out_nxt;

  logic                skid_load, skid_clr, skid_full;
  logic [WORD_LEN-1:0] skid_instr, skid_addr;

  logic [WORD_LEN-1:0] br_addr;
  logic [WORD_LEN-1:0] addr_inc;
  logic [WORD_LEN-1:0] skid_inc;
  logic                slot_free;
  logic                req_pending;

  assign br_addr     = word_align(branch_target);
  assign addr_inc    = next_word(addr_q);
  assign skid_inc    = next_word(skid_addr);
  // The output slot may be overwritten if IF/ID takes it this cycle or it holds a bubble.
  assign slot_free   = !freeze || !out_q.vld;
  // A request is in flight and will not complete this cycle.
  assign req_pending = (state == ST_REQ || state == ST_DISCARD) && !mem.mem_ready;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clr),
    .instr_in (mem.mem_rdata),
    .addr_in  (addr_q),
    .full     (skid_full),
    .instr    (skid_instr),
    .addr     (skid_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      req_q    <= 1'b0;
      addr_q   <= RESET_ADDR;
      target_q <= '0;
      out_q    <= BUBBLE;
    end else begin
      state    <= state_nxt;
      req_q    <= req_nxt;
      addr_q   <= addr_nxt;
      target_q <= target_nxt;
      out_q    <= out_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_nxt    = req_q;
    addr_nxt   = addr_q;
    target_nxt = target_q;
    out_nxt    = out_q;
    skid_load  = 1'b0;
    skid_clr   = 1'b0;

    // A consumed slot becomes a bubble unless something below loads it.
    if (!freeze) begin
      out_nxt = BUBBLE;
    end

    if (branch_taken) begin
      // Current output is wrong-path whether or not IF/ID is frozen.
      out_nxt  = BUBBLE;
      skid_clr = 1'b1;
      if (req_pending) begin
        // Cannot retract the in-flight read: remember where to go once it lands.
        target_nxt = br_addr;
        state_nxt  = ST_DISCARD;
      end else begin
        // Idle, parked, or completing now: any returned word is simply not used.
        req_nxt   = 1'b1;
        addr_nxt  = br_addr;
        state_nxt = ST_REQ;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          req_nxt   = 1'b1;
          addr_nxt  = RESET_ADDR;
          state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (mem.mem_ready) begin
            if (slot_free) begin
              out_nxt  = '{instr: mem.mem_rdata, pc: addr_inc, vld: 1'b1};
              addr_nxt = addr_inc;
            end else begin
              // Slot still owned by IF/ID: park the word and stop fetching.
              skid_load = 1'b1;
              req_nxt   = 1'b0;
              state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!freeze) begin
            out_nxt   = '{instr: skid_instr, pc: skid_inc, vld: skid_full};
            skid_clr  = 1'b1;
            req_nxt   = 1'b1;
            addr_nxt  = skid_inc;
            state_nxt = ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (mem.mem_ready) begin
            req_nxt   = 1'b1;
            addr_nxt  = target_q;
            state_nxt = ST_REQ;
          end
        end
        default: begin
          req_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign PC           = out_q.pc;
  assign instruction  = out_q.instr;
  assign valid        = out_q.vld;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timing cases, then random freeze/branch/latency
// checked against a program-order stream model (memory word at address A is A>>2).
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        tie_lo = 1'b0;
  logic [31:0] tie_tgt = '0;

  logic [31:0] pc0, instr0;
  logic        vld0;
  logic [31:0] pc1, instr1;
  logic        vld1;

  int n_chk = 0;
  int n_err = 0;

  // memory model controls
  int lat = 0;
  bit rand_lat = 1'b0;
  int wait_cnt = 0;
  int cur_lat = 0;
  bit pend = 1'b0;
  logic [31:0] pend_addr = '0;

  // random-phase model state
  logic [31:0] exp_pc;
  logic [31:0] tgt;
  bit          f, b;
  int          consumed;
  int          stall;

  instr_fetch_unit_if mif0();
  instr_fetch_unit_if mif1();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem           (mif0.master),
    .PC            (pc0),
    .instruction   (instr0),
    .valid         (vld0)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .freeze        (tie_lo),
    .branch_taken  (tie_lo),
    .branch_target (tie_tgt),
    .mem           (mif1.master),
    .PC            (pc1),
    .instruction   (instr1),
    .valid         (vld1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, {31'd0, mif0.mem_req}, 32'd0);
    chk({tag, "_addr"}, mif0.mem_addr, 32'd0);
    chk({tag, "_pc"}, pc0, 32'd0);
    chk({tag, "_instr"}, instr0, 32'd0);
    chk({tag, "_vld"}, {31'd0, vld0}, 32'd0);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] p,
                         input logic [31:0] i);
    chk({tag, "_vld"}, {31'd0, vld0}, {31'd0, v});
    chk({tag, "_pc"}, pc0, p);
    chk({tag, "_instr"}, instr0, i);
  endtask

  // Memory for dut0: variable latency, word at address A is A>>2; also checks that a
  // pending request keeps req and addr stable until it completes.
  initial begin
    mif0.mem_ready = 1'b0;
    mif0.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && pend) begin
        chk("req_stable", {31'd0, mif0.mem_req}, 32'd1);
        chk("addr_stable", mif0.mem_addr, pend_addr);
      end
      if (mif0.mem_ready) wait_cnt = 0;
      if (rst && mif0.mem_req) begin
        if (wait_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
        if (wait_cnt >= cur_lat) begin
          mif0.mem_ready = 1'b1;
          mif0.mem_rdata = mif0.mem_addr >> 2;
        end else begin
          mif0.mem_ready = 1'b0;
          mif0.mem_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        mif0.mem_ready = 1'b0;
        wait_cnt = 0;
      end
      pend = rst && mif0.mem_req && !mif0.mem_ready;
      pend_addr = mif0.mem_addr;
    end
  end

  // Memory for dut1: always zero-wait.
  initial begin
    mif1.mem_ready = 1'b0;
    mif1.mem_rdata = '0;
    forever begin
      @(negedge clk);
      mif1.mem_ready = rst && mif1.mem_req;
      mif1.mem_rdata = mif1.mem_addr >> 2;
    end
  end

  initial begin
    // Reset values and zero-wait back-to-back fetch.
    lat = 0;
    rand_lat = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    chk("rst_addr_wrap", mif1.mem_addr, 32'hFFFF_FFFC);
    rst = 1'b1;
    tick();
    chk("zw_req", {31'd0, mif0.mem_req}, 32'd1);
    chk("zw_addr0", mif0.mem_addr, 32'd0);
    chk("zw_vld0", {31'd0, vld0}, 32'd0);
    chk("wrap_addr0", mif1.mem_addr, 32'hFFFF_FFFC);
    tick();
    chk_out("zw_first", 1'b1, 32'd4, 32'd0);
    chk("zw_addr1", mif0.mem_addr, 32'd4);
    chk("wrap_addr1", mif1.mem_addr, 32'd0);
    chk("wrap_pc", pc1, 32'd0);
    chk("wrap_instr", instr1, 32'h3FFF_FFFF);
    chk("wrap_vld", {31'd0, vld1}, 32'd1);
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk_out("zw_seq", 1'b1, 32'(4 * (i + 1)), 32'(i));
    end

    // Three wait states.
    lat = 3;
    apply_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lat_addr", mif0.mem_addr, 32'd0);
      chk("lat_req", {31'd0, mif0.mem_req}, 32'd1);
      chk_out("lat_bubble", 1'b0, 32'd0, 32'd0);
    end
    tick();
    chk_out("lat_done", 1'b1, 32'd4, 32'd0);

    // Freeze across a completing fetch: skid capture and clean resume.
    lat = 0;
    apply_reset();
    tick();
    tick();
    chk_out("frz_pre", 1'b1, 32'd4, 32'd0);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frz_req", {31'd0, mif0.mem_req}, 32'd0);
      chk_out("frz_held", 1'b1, 32'd4, 32'd0);
    end
    freeze = 1'b0;
    tick();
    chk_out("frz_rel", 1'b1, 32'd8, 32'd1);
    chk("frz_rel_req", {31'd0, mif0.mem_req}, 32'd1);
    chk("frz_rel_addr", mif0.mem_addr, 32'd8);
    tick();
    chk_out("frz_next", 1'b1, 32'd12, 32'd2);

    // Branch with freeze while parked: skid dropped, target requested next cycle.
    apply_reset();
    tick();
    tick();
    freeze = 1'b1;
    tick();
    chk("hb_hold_req", {31'd0, mif0.mem_req}, 32'd0);
    branch_taken = 1'b1;
    branch_target = 32'h0000_0103;
    tick();
    chk_out("hb_bubble", 1'b0, 32'd0, 32'd0);
    chk("hb_req", {31'd0, mif0.mem_req}, 32'd1);
    chk("hb_addr", mif0.mem_addr, 32'h100);
    branch_taken = 1'b0;
    freeze = 1'b0;
    tick();
    chk_out("hb_target", 1'b1, 32'h104, 32'h40);

    // Branch while a read is outstanding, then async reset mid-wait.
    lat = 3;
    apply_reset();
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0100;
    tick();
    branch_taken = 1'b0;
    chk_out("bo_bubble", 1'b0, 32'd0, 32'd0);
    chk("bo_addr_a", mif0.mem_addr, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bo_addr_b", mif0.mem_addr, 32'd0);
      chk("bo_req_b", {31'd0, mif0.mem_req}, 32'd1);
    end
    tick();
    chk("bo_addr_tgt", mif0.mem_addr, 32'h100);
    chk("bo_vld_drop", {31'd0, vld0}, 32'd0);
    lat = 0;
    tick();
    chk_out("bo_target", 1'b1, 32'h104, 32'h40);
    freeze = 1'b1;
    lat = 3;
    tick();
    chk_out("rw_held", 1'b1, 32'h104, 32'h40);
    rst = 1'b0;
    #1;
    chk_reset_vals("rw");
    freeze = 1'b0;

    // Random freeze/branch/latency against the stream model.
    rand_lat = 1'b1;
    apply_reset();
    exp_pc = 32'd0;
    consumed = 0;
    stall = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      f = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 6);
      tgt = $urandom & 32'h0000_07FF;
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      if (!vld0) begin
        chk("rnd_bubble_pc", pc0, 32'd0);
        chk("rnd_bubble_instr", instr0, 32'd0);
      end
      if (b) begin
        exp_pc = tgt & ~32'h3;
      end else if (vld0 && !f) begin
        chk("rnd_pc", pc0, exp_pc + 32'd4);
        chk("rnd_instr", instr0, exp_pc >> 2);
        exp_pc = exp_pc + 32'd4;
        consumed++;
        stall = 0;
      end else begin
        stall++;
      end
      if (stall > 100) begin
        chk("rnd_liveness", 32'(stall), 32'd0);
        stall = 0;
      end
      freeze = f;
      branch_taken = b;
      branch_target = tgt;
    end
    freeze = 1'b0;
    branch_taken = 1'b0;
    chk("rnd_progress", {31'd0, consumed > 200}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
